// File: rtl/phase_sequencer.sv
// phase_sequencer: retractile power-clock sequencer that ramps adiabatic levels up, strobes Tclk once,
// then ramps the levels back down in reverse order. Requires NPHASE >= 2 and HOLD_CYCLES >= 1.
module phase_sequencer #(
    parameter int NPHASE      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      Fclk,
    input  logic                      Reset,
    input  logic                      run,
    input  logic                      step,
    input  logic                      stall,
    output logic [0:NPHASE-1]         clkpos,
    output logic [0:NPHASE-1]         clkneg,
    output logic                      Tclk,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NPHASE)-1:0] phase_idx
);
    localparam int LW = $clog2(NPHASE);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [LW-1:0] LAST  = LW'(NPHASE - 1);
    localparam logic [LW-1:0] L_ONE = LW'(1);
    localparam logic [CW-1:0] CMAX  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, UP, CAPTURE, DOWN} state_t;

    state_t           state_q;
    logic [LW-1:0]    level_q;
    logic [CW-1:0]    cnt_q;
    logic [0:NPHASE-1] clkpos_q;
    logic             tclk_q, busy_q, done_q;
    logic             hold_done;

    assign hold_done = cnt_q == CMAX;

    always_ff @(posedge Fclk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            cnt_q    <= '0;
            clkpos_q <= '0;
            tclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tclk_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if ((run | step) & ~stall) begin
                    state_q     <= UP;
                    busy_q      <= 1'b1;
                    level_q     <= '0;
                    cnt_q       <= '0;
                    clkpos_q[0] <= 1'b1;
                end
                UP: if (!stall) begin
                    if (!hold_done) cnt_q <= cnt_q + C_ONE;
                    else if (level_q != LAST) begin
                        level_q                   <= level_q + L_ONE;
                        clkpos_q[level_q + L_ONE] <= 1'b1;
                        cnt_q                     <= '0;
                    end else begin
                        state_q <= CAPTURE;
                        tclk_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_q            <= DOWN;
                    clkpos_q[NPHASE-1] <= 1'b0;
                    cnt_q              <= '0;
                end
                DOWN: if (!stall) begin
                    if (!hold_done) cnt_q <= cnt_q + C_ONE;
                    else begin
                        level_q                   <= level_q - L_ONE;
                        clkpos_q[level_q - L_ONE] <= 1'b0;
                        cnt_q                     <= '0;
                        // Leaving level 1 drops rail 0, which ends the sequence.
                        if (level_q == L_ONE) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clkpos    = clkpos_q;
    assign clkneg    = ~clkpos_q;
    assign Tclk      = tclk_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign phase_idx = level_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed and random checks of phase_sequencer against a progress-count model
// that derives every output from the number of effective cycles elapsed since the start edge.
module tb_phase_sequencer;
    localparam int N    = 10;
    localparam int H    = 4;
    localparam int NH   = N * H;
    localparam int PEND = (2 * N - 1) * H + 1;

    logic Fclk = 1'b0, Reset = 1'b0, run = 1'b0, step = 1'b0, stall = 1'b0;
    logic [0:N-1] clkpos, clkneg;
    logic Tclk, busy, done;
    logic [$clog2(N)-1:0] phase_idx;

    int n_assert = 0, n_fail = 0;
    bit active = 0, m_done = 0;
    int p = 0, cyc_t = 0, base = 0;
    int n_r0 = 0, n_done = 0, t_r0 = -1, t_f0 = -1, t_rl = -1, t_fl = -1, t_tclk = -1, t_done = -1;
    int q_tclk[$], q_r0[$];
    int r0_before, d_before;
    logic prev0 = 1'b0, prevl = 1'b0;
    logic [0:N-1] snap;

    phase_sequencer #(.NPHASE(N), .HOLD_CYCLES(H)) dut (
        .Fclk(Fclk), .Reset(Reset), .run(run), .step(step), .stall(stall),
        .clkpos(clkpos), .clkneg(clkneg), .Tclk(Tclk), .busy(busy), .done(done),
        .phase_idx(phase_idx)
    );

    always #5 Fclk = ~Fclk;

    initial begin
        #1000000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Rail k is up while the ramp-up has reached it and its scheduled fall has not yet come.
    function automatic logic [0:N-1] want_pos();
        logic [0:N-1] v = '0;
        for (int k = 0; k < N; k++)
            v[k] = active && ((p <= NH) ? (k <= p / H) : ((N - 1 - k) * H > p - NH - 1));
        return v;
    endfunction

    function automatic int want_level();
        if (!active) return 0;
        if (p <= NH) return (p / H > N - 1) ? N - 1 : p / H;
        return N - 1 - (p - NH - 1) / H;
    endfunction

    task automatic model_reset();
        active = 0;
        p      = 0;
        m_done = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (Reset) model_reset();
        else if (!active) begin
            if ((run || step) && !stall) begin
                active = 1;
                p      = 0;
            end
        end else if (p == NH || !stall) begin
            p++;
            if (p == PEND) begin
                active = 0;
                p      = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [0:N-1] wp, wn;
        bit therm;
        wp = want_pos();
        wn = ~wp;
        therm = 1;
        chk("clkpos", clkpos, wp);
        chk("clkneg", clkneg, wn);
        chk("Tclk", Tclk, active && p == NH);
        chk("busy", busy, active);
        chk("done", done, m_done);
        chk("phase_idx", phase_idx, want_level());
        for (int k = 0; k < N - 1; k++) if (clkpos[k+1] && !clkpos[k]) therm = 0;
        chk("thermometer", therm, 1);
    endtask

    task automatic tick(input logic r, input logic s, input logic st);
        run   = r;
        step  = s;
        stall = st;
        @(posedge Fclk);
        cyc_t++;
        model_edge();
        #1;
        check_all();
        if (clkpos[0] && !prev0) begin n_r0++; t_r0 = cyc_t; q_r0.push_back(cyc_t); end
        if (!clkpos[0] && prev0) t_f0 = cyc_t;
        if (clkpos[N-1] && !prevl) t_rl = cyc_t;
        if (!clkpos[N-1] && prevl) t_fl = cyc_t;
        if (Tclk) begin t_tclk = cyc_t; q_tclk.push_back(cyc_t); end
        if (done) begin n_done++; t_done = cyc_t; end
        prev0 = clkpos[0];
        prevl = clkpos[N-1];
    endtask

    initial begin
        // Reset values before any clock edge
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_clkneg", clkneg, 10'h3FF);
        tick(0, 0, 0);
        tick(1, 1, 0);
        Reset = 1'b0;

        // Single step
        tick(0, 1, 0);
        base = cyc_t;
        for (int i = 0; i < 90; i++) tick(0, 0, 0);
        chk("step_r0", t_r0 - base, 0);
        chk("step_rise_last", t_rl - base, (N - 1) * H);
        chk("step_tclk", t_tclk - base, NH);
        chk("step_fall_last", t_fl - base, NH + 1);
        chk("step_fall0", t_f0 - base, PEND);
        chk("step_done", t_done - base, PEND);
        chk("step_one_seq", n_r0, 1);

        // Continuous run
        q_tclk.delete();
        q_r0.delete();
        base = cyc_t + 1;
        for (int i = 0; i < 160; i++) tick(1, 0, 0);
        chk("run_tclk_count", q_tclk.size() >= 2, 1);
        chk("run_r0_count", q_r0.size() >= 2, 1);
        if (q_tclk.size() >= 2) begin
            chk("run_tclk0", q_tclk[0] - base, NH);
            chk("run_tclk1", q_tclk[1] - base, NH + PEND + 1);
        end
        if (q_r0.size() >= 2) chk("run_restart", q_r0[1] - base, PEND + 1);
        for (int i = 0; i < 100; i++) tick(0, 0, 0);

        // Stall at level 3 during ramp-up
        tick(0, 1, 0);
        base = cyc_t;
        for (int i = 0; i < 3 * H; i++) tick(0, 0, 0);
        snap = want_pos();
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1);
            chk("stall_freeze", clkpos, snap);
        end
        for (int i = 0; i < 90; i++) tick(0, 0, 0);
        chk("stall_tclk", t_tclk - base, NH + 5);
        chk("stall_done", t_done - base, PEND + 5);

        // Stall in IDLE blocks a run start
        r0_before = n_r0;
        for (int i = 0; i < 10; i++) tick(1, 0, 1);
        chk("idle_stall_nostart", n_r0 - r0_before, 0);
        tick(1, 0, 0);
        chk("idle_stall_release", busy, 1);

        // Asynchronous reset at level 6 while ramping down
        for (int i = 0; i < 200 && !(active && p > NH && want_level() == 6); i++) tick(0, 0, 0);
        chk("reach_down6", phase_idx, 6);
        d_before = n_done;
        #2 Reset = 1'b1;
        #1;
        chk("arst_clkpos", clkpos, 0);
        chk("arst_clkneg", clkneg, 10'h3FF);
        chk("arst_tclk", Tclk, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_phase", phase_idx, 0);
        model_reset();
        prev0 = 1'b0;
        prevl = 1'b0;
        tick(1, 0, 0);
        Reset = 1'b0;
        chk("arst_no_done", n_done - d_before, 0);
        tick(1, 0, 0);
        base = cyc_t;
        for (int i = 0; i < 80; i++) tick(0, 0, 0);
        chk("arst_restart_r0", t_r0 - base, 0);
        chk("arst_restart_done", t_done - base, PEND);

        // Step while busy and run dropped mid-sequence
        r0_before = n_r0;
        d_before  = n_done;
        tick(1, 0, 0);
        for (int i = 1; i < 100; i++) tick(i < 20, i == 10 || i == 50, 0);
        chk("ignored_one_seq", n_r0 - r0_before, 1);
        chk("ignored_one_done", n_done - d_before, 1);

        // Random run/step/stall traffic
        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        for (int i = 0; i < 100; i++) tick(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
